// File: rtl/gray_bcd_decoder_pkg.sv
// Shared types and constants for the multi-digit Gray-to-BCD decoder.
// The state encoding is fixed so that waveforms and debug taps read the same everywhere.
package gray_bcd_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam int         GRAY_DIGIT_W = 4;

endpackage

// File: rtl/gray_bcd_decoder_digit_step.sv
// One digit of the iterative decoder: Gray shift register plus a running XOR,
// producing one BCD bit (MSB first) per step.
module gray_digit_step
  import gray_bcd_decoder_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic [GRAY_DIGIT_W-1:0] gray_nibble,
  output logic [GRAY_DIGIT_W-1:0] bcd_nibble,
  output logic                    gt9
);

  logic [GRAY_DIGIT_W-1:0] sr_q, sr_d;
  logic                    acc_q, acc_d;
  logic [GRAY_DIGIT_W-1:0] wk_q, wk_d;
  logic                    bit_now;

  // The accumulator starts at 0, so the first step yields b3 = g3 directly.
  assign bit_now = acc_q ^ sr_q[GRAY_DIGIT_W-1];

  always_comb begin
    sr_d  = sr_q;
    acc_d = acc_q;
    wk_d  = wk_q;
    if (load) begin
      sr_d  = gray_nibble;
      acc_d = 1'b0;
      wk_d  = '0;
    end else if (step) begin
      sr_d  = {sr_q[GRAY_DIGIT_W-2:0], 1'b0};
      acc_d = bit_now;
      wk_d  = {wk_q[GRAY_DIGIT_W-2:0], bit_now};
    end
  end

  // Exposes the post-step value so the parent can capture the full digit on the last step.
  assign bcd_nibble = wk_d;
  assign gt9        = (wk_d > BCD_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      acc_q <= 1'b0;
      wk_q  <= '0;
    end else begin
      sr_q  <= sr_d;
      acc_q <= acc_d;
      wk_q  <= wk_d;
    end
  end

endmodule

// File: rtl/gray_bcd_decoder.sv
// Packed multi-digit Gray-to-BCD decoder: one bit position per clock, all digits
// in parallel, valid/ready on both sides, with a saturating count of out-of-range results.
module gray_bcd_decoder
  import gray_bcd_decoder_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int CNT_W  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [GRAY_DIGIT_W*DIGITS-1:0] gray_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [GRAY_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                           bcd_err,
  output logic [CNT_W-1:0]               err_count
);

  localparam int W = GRAY_DIGIT_W * DIGITS;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [W-1:0]     bcd_out_q, bcd_out_d;
  logic             bcd_err_q, bcd_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             load, step;
  logic [W-1:0]     bcd_next;
  logic [DIGITS-1:0] gt9;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    gray_digit_step u_step (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .step       (step),
      .gray_nibble(gray_in[gi*GRAY_DIGIT_W +: GRAY_DIGIT_W]),
      .bcd_nibble (bcd_next[gi*GRAY_DIGIT_W +: GRAY_DIGIT_W]),
      .gt9        (gt9[gi])
    );
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bcd_out_d = bcd_out_q;
    bcd_err_d = bcd_err_q;
    err_cnt_d = err_cnt_q;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          idx_d   = 2'd3;
          state_d = DECODE;
        end
      end
      DECODE: begin
        step = 1'b1;
        if (idx_q == 2'd0) begin
          state_d   = DONE;
          bcd_out_d = bcd_next;
          bcd_err_d = |gt9;
        end else begin
          idx_d = idx_q - 2'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (bcd_err_q && (err_cnt_q != {CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      bcd_out_q <= '0;
      bcd_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bcd_out_q <= bcd_out_d;
      bcd_err_q <= bcd_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // in_ready is gated by rst so nothing can be offered while the block is held in reset.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign bcd_out   = bcd_out_q;
  assign bcd_err   = bcd_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_gray_bcd_decoder.sv
// Directed bench for gray_bcd_decoder: hand-computed vectors, a BCD sweep with stalls,
// back-to-back accept spacing, mid-flight reset and counter saturation on a narrow instance.
module tb_gray_bcd_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] gray_in;
  logic       in_ready,  in_ready2;
  logic       out_valid, out_valid2;
  logic [7:0] bcd_out,   bcd_out2;
  logic       bcd_err,   bcd_err2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int n_assert = 0;
  int n_fail   = 0;
  int err8_exp = 0;
  int err2_exp = 0;
  int n_txn    = 0;

  always #5 clk = ~clk;

  gray_bcd_decoder #(.DIGITS(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .gray_in(gray_in),
    .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out), .bcd_err(bcd_err),
    .err_count(err_count)
  );

  gray_bcd_decoder #(.DIGITS(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .gray_in(gray_in),
    .out_valid(out_valid2), .out_ready(out_ready), .bcd_out(bcd_out2), .bcd_err(bcd_err2),
    .err_count(err_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Full transaction: offer word, check 4-cycle latency, stall, handshake, counters.
  task automatic send(input logic [7:0] g, input logic [7:0] exp_bcd, input logic exp_err,
                      input int stall);
    int wait_n = 0;
    while (!in_ready && wait_n < 20) begin
      tick();
      wait_n++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    gray_in  = g;
    tick();
    in_valid = 1'b0;
    gray_in  = ~g;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("out_valid_during_decode", 32'(out_valid), 32'd0);
      chk("in_ready_during_decode", 32'(in_ready), 32'd0);
    end
    tick();
    chk("out_valid_at_latency4", 32'(out_valid), 32'd1);
    chk("bcd_out", 32'(bcd_out), 32'(exp_bcd));
    chk("bcd_err", 32'(bcd_err), 32'(exp_err));
    chk("bcd_out_sat_inst", 32'(bcd_out2), 32'(exp_bcd));
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        tick();
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_bcd_out", 32'(bcd_out), 32'(exp_bcd));
        chk("stall_bcd_err", 32'(bcd_err), 32'(exp_err));
        chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    tick();
    if (exp_err) begin
      if (err8_exp < 255) err8_exp++;
      if (err2_exp < 3)   err2_exp++;
    end
    chk("out_valid_after_handshake", 32'(out_valid), 32'd0);
    chk("err_count", 32'(err_count), 32'(err8_exp));
    chk("err_count_sat", 32'(err_count2), 32'(err2_exp));
    chk("bcd_out_held_idle", 32'(bcd_out), 32'(exp_bcd));
    n_txn++;
    $display("txn %0d gray=%02h bcd=%02h err=%0b stall=%0d cnt8=%0d cnt2=%0d",
             n_txn, g, bcd_out, bcd_err, stall, err_count, err_count2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    gray_in   = 8'h1D;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_bcd_out", 32'(bcd_out), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    tick();
    tick();
    chk("reset_held_in_valid_ignored", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Hand-computed vectors
    send(8'b0001_1101, 8'h19, 1'b0, 0);
    send(8'b0000_1111, 8'b0000_1010, 1'b1, 2);

    // Reset two cycles after an accept drops the word
    in_valid = 1'b1;
    gray_in  = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_bcd_out", 32'(bcd_out), 32'd0);
    chk("midreset_bcd_err", 32'(bcd_err), 32'd0);
    chk("midreset_err_count", 32'(err_count), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst      = 1'b0;
    err8_exp = 0;
    err2_exp = 0;
    #1;
    chk("after_reset_in_ready", 32'(in_ready), 32'd1);
    send(8'b0010_0111, 8'h35, 1'b0, 1);

    // Five error words: narrow counter saturates at 3
    for (int k = 0; k < 5; k++) send(8'b0000_1111, 8'h0A, 1'b1, k % 2);

    // All two-digit BCD values through the Gray encoding, with random stalls
    for (int hi = 0; hi < 10; hi++) begin
      for (int lo = 0; lo < 10; lo++) begin
        w = {to_gray(4'(hi)), to_gray(4'(lo))};
        send(w, {4'(hi), 4'(lo)}, 1'b0, int'($urandom_range(0, 3)));
      end
    end

    // in_valid held high: accepts every 6 cycles
    gray_in  = 8'b0001_1101;
    in_valid = 1'b1;
    tick();
    for (int c = 1; c <= 17; c++) begin
      tick();
      chk("b2b_in_ready", 32'(in_ready), 32'((c % 6) == 5));
      chk("b2b_out_valid", 32'(out_valid), 32'((c % 6) == 4));
      if ((c % 6) == 4) chk("b2b_bcd_out", 32'(bcd_out), 32'h19);
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_final_idle", 32'(in_ready), 32'd1);
    $display("txn b2b in_valid-held run complete, cnt8=%0d", err_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
